ship_placement_cursor: RTL and testbench
========================================

SHIP_PLACEMENT_CURSOR -- requirements
Module: ship_placement_cursor

Interface
REQ-001 Parameter GRID_SIZE, default 10, board edge length in cells (1..15).
REQ-002 Parameter SHIP_LEN, default 3, ship length in cells (1..GRID_SIZE).
REQ-003 Parameter COORD_W, default 4, bits per coordinate.
REQ-004 Parameter DEBOUNCE_CYCLES, default 16, stable-sample count for debounce.
REQ-005 clk  input  1  system clock, all logic rising-edge.
REQ-006 reset  input  1  asynchronous, active-low.
REQ-007 start  input  1  level, sampled synchronously; IDLE->EDIT request.
REQ-008 btn_select  input  1  raw active-low button, async; move +X.
REQ-009 btn_enter  input  1  raw active-low button, async; move +Y.
REQ-010 btn_rotate  input  1  raw active-low button, async; toggle orientation.
REQ-011 btn_confirm  input  1  raw active-low button, async; commit placement.
REQ-012 place_ready  input  1  memory-side accept for committed placement.
REQ-013 positions  output  SHIP_LEN*2*COORD_W  packed cells; cell i at [i*2*COORD_W +: 2*COORD_W], low COORD_W = X, high COORD_W = Y.
REQ-014 place_valid  output  1  committed placement offered to memory.
REQ-015 vertical  output  1  orientation, 0 = horizontal (cells along +X).
REQ-016 state  output  2  current FSM state code.

Function
REQ-017 Each button SHALL pass a 2-flop synchronizer then a falling-edge detector yielding a one-cycle press pulse; held buttons SHALL produce one pulse only.
REQ-018 Coordinates SHALL be 1-based; value 0 SHALL mean "no ship"; anchor (AX,AY) is cell 0.
REQ-019 Cell i SHALL be (AX+i, AY) when horizontal, (AX, AY+i) when vertical, computed combinationally from registered anchor/orientation.
REQ-020 FSM states: IDLE=0, EDIT=1, COMMIT=2, DONE=3.
REQ-021 IDLE: positions all zero, place_valid 0; start=1 SHALL go to EDIT with anchor (1,1), horizontal.
REQ-022 EDIT, select pulse: AX+1; if horizontal and AX+SHIP_LEN-1 would exceed GRID_SIZE, or vertical and AX would exceed GRID_SIZE, AX SHALL wrap to 1.
REQ-023 EDIT, enter pulse: same rule on AY with axes swapped.
REQ-024 EDIT, rotate pulse: toggle orientation; anchor on new long axis SHALL clamp to GRID_SIZE-SHIP_LEN+1 if larger; other axis unchanged.
REQ-025 EDIT, confirm pulse: go to COMMIT; place_valid SHALL assert the next cycle.
REQ-026 Pulses in same cycle: priority confirm > rotate > select > enter; lower-priority pulses SHALL be discarded, not queued.
REQ-027 Every cell produced in EDIT SHALL satisfy 1 <= X,Y <= GRID_SIZE.
REQ-028 COMMIT: place_valid held 1, positions frozen, all button pulses ignored; place_valid && place_ready SHALL go to DONE next cycle, place_valid deasserting then.
REQ-029 DONE: positions held, place_valid 0; start=1 SHALL return to IDLE.
REQ-030 Movement latency: raw press to updated positions = 3 clk cycles without debounce.

Reset
REQ-031 reset low SHALL immediately force state IDLE, anchor (0,0), horizontal, place_valid 0, positions zero, synchronizer/edge flops to released (1), debounce counters 0.
REQ-032 Reset asserted during COMMIT SHALL drop place_valid without waiting for place_ready.
REQ-033 Buttons held low through reset release SHALL not generate a pulse.

Configuration
REQ-034 Macro BUTTON_DEBOUNCE_EN defined: synchronized level SHALL update only after DEBOUNCE_CYCLES consecutive equal samples; latency becomes 3+DEBOUNCE_CYCLES cycles.
REQ-035 Macro BUTTON_DEBOUNCE_EN undefined: synchronizer output drives edge detector directly; DEBOUNCE_CYCLES unused.

Structure
REQ-036 Shared package batalha_pkg SHALL hold FSM state codes, orientation constants, COORD_W default and the cell packing width helper.
REQ-037 Sub-module button_conditioner (synchronizer, optional debounce, falling-edge pulse) SHALL be instantiated four times.

Verification
REQ-038 Reset, start=1 -> state EDIT, positions cells (1,1),(2,1),(3,1), vertical 0.
REQ-039 Defaults, 7 select presses from (1,1) horizontal -> AX=8 (cells to X=10); 8th press -> AX=1.
REQ-040 Anchor (1,9) horizontal, rotate -> vertical, AY clamped to 8, cells (1,8),(1,9),(1,10).
REQ-041 Confirm and select in same cycle -> COMMIT, anchor unchanged; hold place_ready 0 for 5 cycles -> place_valid stays 1, positions frozen; place_ready 1 -> DONE next cycle.
REQ-042 Reset asserted in COMMIT -> place_valid 0 and positions zero without a clock edge.
REQ-043 BUTTON_DEBOUNCE_EN, DEBOUNCE_CYCLES=16: 10-cycle glitch on btn_select -> no move; 20-cycle press -> exactly one move.

Source files
------------

// File: rtl/batalha_pkg.sv
// Shared definitions for the ship placement block.
// Holds the FSM state codes, the orientation constants, the default
// coordinate width and the packed-cell width helper.
package batalha_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StEdit   = 2'd1,
    StCommit = 2'd2,
    StDone   = 2'd3
  } state_e;

  localparam logic OrientHorizontal = 1'b0;
  localparam logic OrientVertical   = 1'b1;

  localparam int unsigned CoordWDefault = 4;

  // Width of the packed cell vector: each cell carries an X and a Y coordinate.
  function automatic int unsigned cells_width(input int unsigned ship_len,
                                              input int unsigned coord_w);
    return ship_len * 2 * coord_w;
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Conditions one raw active-low push button into a single-cycle press pulse.
// Optional debounce is compiled in when BUTTON_DEBOUNCE_EN is defined.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous, active-low
//   btn_raw  raw asynchronous button level, 0 = pressed
//   pulse    one-cycle pulse on each press (falling edge of the conditioned level)
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic pulse
);

  logic       sync1_q, sync2_q;
  logic       level;
  logic       prev_q;
  logic [1:0] fill_q;
  logic       armed_q, armed_d;

  if (DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("button_conditioner: DEBOUNCE_CYCLES must be at least 1");
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      fill_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= level;
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= armed_d;
    end
  end

`ifdef BUTTON_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;

  // Level follows the synchronizer only after DEBOUNCE_CYCLES consecutive
  // samples that disagree with the current level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      level_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
`else
  assign level = sync2_q;
`endif

  // Pulses are suppressed until the button has been seen released after
  // reset, so a button held through reset release never fires. fill_q[1]
  // marks that sync2_q holds a real sample rather than its reset value.
  always_comb begin
    armed_d = armed_q | (fill_q[1] & sync2_q & level);
  end

  assign pulse = armed_q & prev_q & ~level;

endmodule

// File: rtl/ship_placement_cursor.sv
// Ship placement cursor: moves and rotates a ship on a square board using
// four push buttons, then offers the committed cell list to memory.
// Optional button debounce: define BUTTON_DEBOUNCE_EN.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low
//   start        IDLE->EDIT request, and DONE->IDLE return
//   btn_select   raw active-low button, move anchor +X
//   btn_enter    raw active-low button, move anchor +Y
//   btn_rotate   raw active-low button, toggle orientation
//   btn_confirm  raw active-low button, commit placement
//   place_ready  memory-side accept of the committed placement
//   positions    packed cells, cell i at [i*2*COORD_W +: 2*COORD_W], X low, Y high
//   place_valid  committed placement offered to memory
//   vertical     orientation, 0 = horizontal
//   state        current FSM state code
module ship_placement_cursor
  import batalha_pkg::*;
#(
  parameter int unsigned GRID_SIZE       = 10,
  parameter int unsigned SHIP_LEN        = 3,
  parameter int unsigned COORD_W         = CoordWDefault,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic                                      btn_select,
  input  logic                                      btn_enter,
  input  logic                                      btn_rotate,
  input  logic                                      btn_confirm,
  input  logic                                      place_ready,
  output logic [cells_width(SHIP_LEN, COORD_W)-1:0] positions,
  output logic                                      place_valid,
  output logic                                      vertical,
  output logic [1:0]                                state
);

  localparam int unsigned CellW = 2 * COORD_W;

  // Largest anchor on the long axis that still keeps the whole ship on board.
  localparam logic [COORD_W-1:0] MaxLong = COORD_W'(GRID_SIZE - SHIP_LEN + 1);
  localparam logic [COORD_W-1:0] Grid    = COORD_W'(GRID_SIZE);
  localparam logic [COORD_W-1:0] One     = COORD_W'(1);

  logic sel_p, ent_p, rot_p, cfm_p;

  state_e             state_q, state_d;
  logic [COORD_W-1:0] ax_q, ax_d;
  logic [COORD_W-1:0] ay_q, ay_d;
  logic               vert_q, vert_d;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_cond_select (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_select),
    .pulse  (sel_p)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_cond_enter (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_enter),
    .pulse  (ent_p)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_cond_rotate (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_rotate),
    .pulse  (rot_p)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_cond_confirm (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_confirm),
    .pulse  (cfm_p)
  );

  always_comb begin
    state_d = state_q;
    ax_d    = ax_q;
    ay_d    = ay_q;
    vert_d  = vert_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StEdit;
          ax_d    = One;
          ay_d    = One;
          vert_d  = OrientHorizontal;
        end
      end
      StEdit: begin
        // Single action per cycle; lower-priority pulses are dropped.
        if (cfm_p) begin
          state_d = StCommit;
        end else if (rot_p) begin
          vert_d = ~vert_q;
          if (vert_q == OrientHorizontal) begin
            if (ay_q > MaxLong) ay_d = MaxLong;
          end else begin
            if (ax_q > MaxLong) ax_d = MaxLong;
          end
        end else if (sel_p) begin
          // Wrap tests compare the current anchor so the +1 never overflows.
          if (vert_q == OrientVertical) begin
            ax_d = (ax_q >= Grid) ? One : ax_q + One;
          end else begin
            ax_d = (ax_q >= MaxLong) ? One : ax_q + One;
          end
        end else if (ent_p) begin
          if (vert_q == OrientVertical) begin
            ay_d = (ay_q >= MaxLong) ? One : ay_q + One;
          end else begin
            ay_d = (ay_q >= Grid) ? One : ay_q + One;
          end
        end
      end
      StCommit: begin
        if (place_ready) state_d = StDone;
      end
      StDone: begin
        if (start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      ax_q    <= '0;
      ay_q    <= '0;
      vert_q  <= OrientHorizontal;
    end else begin
      state_q <= state_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      vert_q  <= vert_d;
    end
  end

  // Cells are derived from the registered anchor; IDLE reports no ship.
  always_comb begin
    positions = '0;
    if (state_q != StIdle) begin
      for (int i = 0; i < SHIP_LEN; i++) begin
        positions[i*CellW +: COORD_W] =
            ax_q + ((vert_q == OrientVertical) ? '0 : COORD_W'(i));
        positions[i*CellW + COORD_W +: COORD_W] =
            ay_q + ((vert_q == OrientVertical) ? COORD_W'(i) : '0);
      end
    end
  end

  assign place_valid = (state_q == StCommit);
  assign vertical    = vert_q;
  assign state       = state_q;

endmodule

// File: tb/tb_ship_placement_cursor.sv
module tb_ship_placement_cursor;

`ifdef BUTTON_DEBOUNCE_EN
  localparam int Deb = 16;
`else
  localparam int Deb = 0;
`endif
  localparam int Lat  = 3 + Deb;
  localparam int Hold = Lat + 3;

  logic        clk = 1'b0;
  logic        reset, start, place_ready;
  logic        btn_select, btn_enter, btn_rotate, btn_confirm;
  logic [23:0] positions;
  logic        place_valid, vertical;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_bad = 0;

  ship_placement_cursor #(
    .GRID_SIZE      (10),
    .SHIP_LEN       (3),
    .COORD_W        (4),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .btn_select (btn_select),
    .btn_enter  (btn_enter),
    .btn_rotate (btn_rotate),
    .btn_confirm(btn_confirm),
    .place_ready(place_ready),
    .positions  (positions),
    .place_valid(place_valid),
    .vertical   (vertical),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mask bits: {confirm, rotate, enter, select}
  task automatic press(input logic [3:0] mask);
    @(negedge clk);
    btn_select  = ~mask[0];
    btn_enter   = ~mask[1];
    btn_rotate  = ~mask[2];
    btn_confirm = ~mask[3];
    repeat (Hold) @(negedge clk);
    btn_select  = 1'b1;
    btn_enter   = 1'b1;
    btn_rotate  = 1'b1;
    btn_confirm = 1'b1;
    repeat (Hold) @(negedge clk);
  endtask

  initial begin
    // Reset with start high and select held low through reset release.
    reset       = 1'b0;
    start       = 1'b1;
    place_ready = 1'b0;
    btn_select  = 1'b0;
    btn_enter   = 1'b1;
    btn_rotate  = 1'b1;
    btn_confirm = 1'b1;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_positions", 32'(positions), 32'h0);
    check("rst_place_valid", 32'(place_valid), 32'd0);
    check("rst_vertical", 32'(vertical), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("start_state_edit", 32'(state), 32'd1);
    check("held_btn_no_pulse", 32'(positions), 32'h131211);
    start      = 1'b0;
    btn_select = 1'b1;
    repeat (Hold) @(negedge clk);
    check("release_no_pulse", 32'(positions), 32'h131211);

    // Press-to-position latency.
    btn_select = 1'b0;
    repeat (Lat - 1) @(negedge clk);
    check("latency_before", 32'(positions), 32'h131211);
    @(negedge clk);
    check("latency_after", 32'(positions), 32'h141312);
    repeat (Hold) @(negedge clk);
    btn_select = 1'b1;
    repeat (Hold) @(negedge clk);
    check("held_one_pulse", 32'(positions), 32'h141312);

    // AX 2 -> 8 (cells reach X=10), then wrap to 1.
    repeat (6) press(4'b0001);
    check("select_to_edge", 32'(positions), 32'h1A1918);
    press(4'b0001);
    check("select_wrap", 32'(positions), 32'h131211);

    // AY 1 -> 9, horizontal.
    repeat (8) press(4'b0010);
    check("enter_to_9", 32'(positions), 32'h939291);

    // Rotate clamps AY to 8.
    press(4'b0100);
    check("rotate_clamp", 32'(positions), 32'hA19181);
    check("rotate_vertical", 32'(vertical), 32'd1);

    // Vertical enter from AY=8 wraps to 1.
    press(4'b0010);
    check("vert_enter_wrap", 32'(positions), 32'h312111);

    press(4'b0100);
    check("rotate_back", 32'(positions), 32'h131211);
    check("rotate_horizontal", 32'(vertical), 32'd0);
    press(4'b0001);
    check("select_again", 32'(positions), 32'h141312);

    // Confirm and select together: confirm wins, select discarded.
    press(4'b1001);
    check("confirm_state", 32'(state), 32'd2);
    check("confirm_anchor", 32'(positions), 32'h141312);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("commit_hold_valid", 32'(place_valid), 32'd1);
    end
    press(4'b0101);
    check("commit_ignores_btn", 32'(positions), 32'h141312);
    check("commit_ignores_rot", 32'(vertical), 32'd0);
    check("commit_still", 32'(state), 32'd2);
    place_ready = 1'b1;
    @(negedge clk);
    check("done_state", 32'(state), 32'd3);
    check("done_valid_low", 32'(place_valid), 32'd0);
    check("done_positions", 32'(positions), 32'h141312);
    place_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_to_idle", 32'(state), 32'd0);
    check("idle_positions", 32'(positions), 32'h0);

    // Reset during COMMIT drops place_valid with no clock edge.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("reenter_edit", 32'(state), 32'd1);
    press(4'b1000);
    check("commit_valid", 32'(place_valid), 32'd1);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("async_rst_valid", 32'(place_valid), 32'd0);
    check("async_rst_positions", 32'(positions), 32'h0);
    check("async_rst_state", 32'(state), 32'd0);
    @(negedge clk);
    reset = 1'b1;

`ifdef BUTTON_DEBOUNCE_EN
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (Hold) @(negedge clk);
    btn_select = 1'b0;
    repeat (10) @(negedge clk);
    btn_select = 1'b1;
    repeat (30) @(negedge clk);
    check("debounce_glitch", 32'(positions), 32'h131211);
    btn_select = 1'b0;
    repeat (20) @(negedge clk);
    btn_select = 1'b1;
    repeat (30) @(negedge clk);
    check("debounce_press", 32'(positions), 32'h141312);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
